// File: rtl/wr_sequencer_pkg.sv
// wr_sequencer shared definitions: FSM encoding and array-wide defaults.
// Imported by the sequencer, its counter and its interface users.
package wr_sequencer_pkg;

  localparam int WIDTH_HEIGHT_DEF = 16;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_LAT = 3'd1;
  localparam logic [2:0] S_ACTIVE   = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wr_sequencer_if.sv
// Command/status bundle between the array controller and wr_sequencer.
// master = controller side, slave = sequencer side.
interface wr_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int LAT_WIDTH  = 6
);

  logic                  start;
  logic [CNT_WIDTH-1:0]  num_rows;
  logic [LAT_WIDTH-1:0]  array_latency;
  logic [ADDR_WIDTH-1:0] base_addr_in;
  logic                  busy;
  logic                  wr_active;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  row_count;
  logic                  done;

  modport master (
    output start, num_rows, array_latency, base_addr_in,
    input  busy, wr_active, base_addr, row_count, done
  );

  modport slave (
    input  start, num_rows, array_latency, base_addr_in,
    output busy, wr_active, base_addr, row_count, done
  );

endinterface

// File: rtl/wr_sequencer_load_down_counter.sv
// Loadable down counter that saturates at zero and flags a count of one,
// so the owner can leave its state on the last counted cycle.
module load_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/wr_sequencer.sv
// Write-phase sequencer: waits out array latency, then holds wr_active
// for num_rows + WIDTH_HEIGHT - 1 cycles and pulses done.
module wr_sequencer
  import wr_sequencer_pkg::*;
#(
  parameter int WIDTH_HEIGHT = WIDTH_HEIGHT_DEF,
  parameter int ADDR_WIDTH   = 8,
  parameter int CNT_WIDTH    = 8,
  parameter int LAT_WIDTH    = 6
) (
  input  logic          clk,
  input  logic          reset,
  wr_sequencer_if.slave bus
);

  localparam int DW = cnt_bits(WIDTH_HEIGHT);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(WIDTH_HEIGHT - 1);

  logic [2:0]            state;
  logic [2:0]            nxt;
  logic [CNT_WIDTH-1:0]  rows_q;
  logic [CNT_WIDTH-1:0]  row_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LAT_WIDTH-1:0]  lat_cnt;
  logic [DW-1:0]         drain_cnt;
  logic                  lat_one;
  logic                  drain_one;
  logic                  accept;
  logic                  last_row;

  assign accept   = (state == S_IDLE) && bus.start;
  assign last_row = (row_q == rows_q - CNT_WIDTH'(1));

  load_down_counter #(.WIDTH(LAT_WIDTH)) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (bus.array_latency),
    .dec      (state == S_WAIT_LAT),
    .count    (lat_cnt),
    .is_one   (lat_one)
  );

  load_down_counter #(.WIDTH(DW)) u_drain (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == S_ACTIVE) && last_row),
    .load_val (DRAIN_LOAD),
    .dec      (state == S_DRAIN),
    .count    (drain_cnt),
    .is_one   (drain_one)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.num_rows == '0)
            nxt = S_DONE;
          else if (bus.array_latency == '0)
            nxt = S_ACTIVE;
          else
            nxt = S_WAIT_LAT;
        end
      end
      S_WAIT_LAT: if (lat_one) nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (last_row)
          nxt = (WIDTH_HEIGHT > 1) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: if (drain_one) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_q <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else if (accept) begin
      rows_q <= bus.num_rows;
      row_q  <= '0;
      base_q <= bus.base_addr_in;
    end else if (state == S_ACTIVE) begin
      row_q  <= row_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.wr_active = (state == S_ACTIVE) || (state == S_DRAIN);
    bus.done      = (state == S_DONE);
    bus.base_addr = base_q;
    bus.row_count = row_q;
  end

endmodule

// File: tb/tb_wr_sequencer.sv
// Randomised + directed bench for wr_sequencer against a timing model
// that derives every output from the cycle offset since the last accepted start.
module tb_wr_sequencer;

  localparam int WH = 16;

  logic clk = 1'b0;
  logic reset;

  wr_sequencer_if #(.ADDR_WIDTH(8), .CNT_WIDTH(8), .LAT_WIDTH(6)) bus ();

  wr_sequencer #(
    .WIDTH_HEIGHT (WH),
    .ADDR_WIDTH   (8),
    .CNT_WIDTH    (8),
    .LAT_WIDTH    (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  bit have = 0;
  int k, m_n, m_l, m_b;
  int act_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_idle();
    int d, e;
    if (!have) return 1'b1;
    d = cyc - k;
    e = (m_n == 0) ? 1 : m_l + m_n + WH;
    return d > e;
  endfunction

  task automatic step(input bit st, input int n, input int l,
                      input int b, input bit rs);
    int d, e, r;
    bit e_busy, e_act, e_done;
    bus.start         = st;
    bus.num_rows      = n[7:0];
    bus.array_latency = l[5:0];
    bus.base_addr_in  = b[7:0];
    reset             = rs;
    @(posedge clk);
    if (rs) begin
      have = 1'b0;
    end else if (st && m_idle()) begin
      have = 1'b1;
      k = cyc;
      m_n = n & 8'hff;
      m_l = l & 6'h3f;
      m_b = b & 8'hff;
    end
    cyc++;
    @(negedge clk);
    d = cyc - k;
    e = (m_n == 0) ? 1 : m_l + m_n + WH;
    e_busy = have && d >= 1 && d <= e;
    e_act  = have && m_n > 0 && d >= m_l + 1 && d <= e - 1;
    e_done = have && d == e;
    r = 0;
    if (have && m_n > 0) begin
      r = d - m_l - 1;
      if (r < 0) r = 0;
      if (r > m_n) r = m_n;
    end
    if (bus.wr_active === 1'b1) act_cnt++;
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("wr_active", 32'(bus.wr_active), 32'(e_act));
    chk("done", 32'(bus.done), 32'(e_done));
    chk("row_count", 32'(bus.row_count), 32'(r));
    chk("base_addr", 32'(bus.base_addr), have ? 32'(m_b) : 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, $urandom_range(0, 255), $urandom_range(0, 63),
           $urandom_range(0, 255), 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.num_rows = '0;
    bus.array_latency = '0;
    bus.base_addr_in = '0;
    reset = 1'b1;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    idle(2);

    // basic command N=4 L=3
    step(1, 4, 3, 8'h20, 0);
    idle(26);

    // zero latency single row
    step(1, 1, 0, 8'h11, 0);
    idle(20);

    // zero rows: one-cycle done
    step(1, 0, 5, 8'h33, 0);
    idle(4);

    // start during ACTIVE ignored
    step(1, 4, 3, 8'h20, 0);
    idle(4);
    step(1, 9, 2, 8'h55, 0);
    idle(22);

    // reset mid-DRAIN, then fresh command
    step(1, 4, 3, 8'h20, 0);
    idle(14);
    step(0, 0, 0, 0, 1);
    idle(3);
    step(1, 2, 1, 8'h42, 0);
    idle(22);

    // max rows and latency, back-to-back start after done
    act_cnt = 0;
    step(1, 255, 63, 8'hc3, 0);
    idle(334);
    chk("act_len", 32'(act_cnt), 32'd270);
    step(1, 3, 2, 8'h07, 0);
    idle(24);

    // randomised traffic
    for (int i = 0; i < 2500; i++) begin
      bit rs, st;
      int n, l;
      rs = ($urandom_range(0, 299) == 0);
      st = ($urandom_range(0, 7) == 0);
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                      : $urandom_range(0, 12);
      l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)
                                      : $urandom_range(0, 3);
      step(st, n, l, $urandom_range(0, 255), rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wr_sequencer.md
Name: wr_sequencer

Overview:
- Write-phase sequencer for the systolic array output path; sits directly upstream of the per-lane write-enable/address generator feeding memArr.
- Accepts a one-cycle start command with row count, array pipeline latency and base address.
- Waits out the array latency, then holds the generator's active input high for num_rows + WIDTH_HEIGHT - 1 cycles. This covers the diagonal enable fill plus drain.
- Reports busy, progress and a one-cycle done pulse to the top-level controller.

Parameters:
- WIDTH_HEIGHT, 16, array dimension / number of write lanes; sets drain length.
- ADDR_WIDTH, 8, width of the base-address field per lane.
- CNT_WIDTH, 8, width of num_rows and row_count.
- LAT_WIDTH, 6, width of array_latency.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- num_rows  input  CNT_WIDTH  rows to write; captured on accepted start.
- array_latency  input  LAT_WIDTH  cycles from start to first valid array output; captured on accepted start.
- base_addr_in  input  ADDR_WIDTH  memory base address; captured on accepted start.
- busy  output  1  high in every non-IDLE state.
- wr_active  output  1  drives the write generator's active input.
- base_addr  output  ADDR_WIDTH  captured base; held until the next accepted start.
- row_count  output  CNT_WIDTH  rows issued so far in this command.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: reset=1 at a clock edge forces state IDLE, all counters and outputs to 0 in the next cycle. This applies in any state. A mid-operation reset aborts with no done pulse.
- All outputs are decoded from registered state and counters (Moore). There is no combinational path from inputs to outputs.
- States: IDLE, WAIT_LAT, ACTIVE, DRAIN, DONE.
- IDLE, start=1 in cycle k:
  - Capture num_rows, array_latency and base_addr_in.
  - Clear row_count.
  - Next state: DONE if num_rows==0; else ACTIVE if array_latency==0; else WAIT_LAT with lat_cnt=array_latency.
- WAIT_LAT: lat_cnt decrements each cycle. Transition to ACTIVE when lat_cnt==1, giving exactly array_latency cycles in WAIT_LAT.
- ACTIVE:
  - wr_active=1; row_count increments each cycle.
  - After num_rows cycles, go to DRAIN with drain_cnt=WIDTH_HEIGHT-1.
  - row_count ends equal to num_rows. It never wraps: the 255 maximum is reached exactly, with no overflow.
- DRAIN: wr_active=1 and row_count holds. drain_cnt decrements; go to DONE after WIDTH_HEIGHT-1 cycles.
- DONE: wr_active=0, busy=1, done=1 for exactly one cycle, then IDLE.
- Timing from start in cycle k, with L=array_latency and N=num_rows > 0:
  - wr_active is high in cycles k+1+L through k+L+N+WIDTH_HEIGHT-1 inclusive.
  - done is high in cycle k+L+N+WIDTH_HEIGHT.
- start outside IDLE is ignored; captured values do not change.
- start in the cycle after DONE (already IDLE) is accepted, giving back-to-back commands.
- Widths: drain_cnt is clog2(WIDTH_HEIGHT) bits; lat_cnt is LAT_WIDTH bits. There are no arithmetic carries across the total active length.

Decomposition:
- Shared package/include holds:
  - state encoding (3-bit localparams S_IDLE=0, S_WAIT_LAT=1, S_ACTIVE=2, S_DRAIN=3, S_DONE=4);
  - WIDTH_HEIGHT default 16, common to the array control blocks.
- One natural sub-module: load_down_counter.
  - Parameterised width; ports: load, load value, decrement enable, count, is_one flag.
  - Instantiated twice, for lat_cnt and drain_cnt.
- FSM and row_count live in wr_sequencer.

Test Plan:
1. Reset, then start with num_rows=4, array_latency=3, base_addr_in=0x20 in cycle k:
   - busy high k+1..k+23; wr_active high k+4..k+22 (19 cycles);
   - row_count=4 from k+8; done only at k+23; base_addr=0x20 throughout.
2. num_rows=1, array_latency=0: wr_active high k+1..k+16, done at k+17, row_count=1.
3. num_rows=0, array_latency=5: wr_active never high; busy and done high in k+1 only; IDLE at k+2.
4. start with base_addr_in=0x55 and num_rows=9 asserted during ACTIVE of a num_rows=4, base 0x20 command: ignored; base_addr stays 0x20 and the timing matches scenario 1.
5. reset pulsed during DRAIN:
   - next cycle all outputs 0 and no done pulse;
   - a subsequent start with num_rows=2, latency=1 gives wr_active k+2..k+18 and done at k+19.
6. num_rows=255, array_latency=63:
   - row_count reaches 255 without wrap; wr_active high 270 cycles;
   - start in the cycle after done is accepted (busy high the next cycle).
